// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM encoding and divide-by-zero quotient.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam int unsigned MAX_WIDTH = 64;

  // All-ones quotient reported on divide by zero; truncated to WIDTH where used
  localparam logic [MAX_WIDTH-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, compare, conditionally subtract.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] dsr,
  output logic [WIDTH-1:0] rem_c,
  output logic [WIDTH-1:0] dvd_c
);

  logic [WIDTH:0]   partial;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    partial = {rem, dvd[WIDTH-1]};
    ge      = partial >= {1'b0, dsr};
    // partial < 2*dsr always holds, so the difference fits in WIDTH bits
    diff    = WIDTH'(partial - {1'b0, dsr});
    rem_c   = ge ? diff : partial[WIDTH-1:0];
    dvd_c   = {dvd[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned integer divider, one quotient bit per clock, results held after done.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign,
  input  logic             cancel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state, state_next;
  logic             load, step, finish;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q, dvd_q, dsr_q;
  logic             neg_q, neg_r, dz_q;
  logic [WIDTH-1:0] rem_c, dvd_c;
  logic             dvd_neg, dsr_neg, dsr_zero;
  logic [WIDTH-1:0] abs_dvd, abs_dsr;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem   (rem_q),
    .dvd   (dvd_q),
    .dsr   (dsr_q),
    .rem_c (rem_c),
    .dvd_c (dvd_c)
  );

  // Operand magnitudes; |MIN| wraps to MIN, which is the correct unsigned magnitude
  always_comb begin
    dvd_neg  = sign & dividend[WIDTH-1];
    dsr_neg  = sign & divisor[WIDTH-1];
    dsr_zero = (divisor == '0);
    abs_dvd  = dvd_neg ? -dividend : dividend;
    abs_dsr  = dsr_neg ? -divisor : divisor;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !cancel) begin
          load       = 1'b1;
          state_next = dsr_zero ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        if (cancel) begin
          state_next = S_IDLE;
        end else begin
          step = 1'b1;
          if (cnt == '0) state_next = S_FIX;
        end
      end
      S_FIX: begin
        state_next = S_IDLE;
        finish     = !cancel;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Working registers; divide by zero keeps the raw dividend for the remainder
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      rem_q <= '0;
      dvd_q <= '0;
      dsr_q <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz_q  <= 1'b0;
    end else if (load) begin
      cnt   <= CW'(WIDTH - 1);
      rem_q <= '0;
      dvd_q <= dsr_zero ? dividend : abs_dvd;
      dsr_q <= abs_dsr;
      neg_q <= dvd_neg ^ dsr_neg;
      neg_r <= dvd_neg;
      dz_q  <= dsr_zero;
    end else if (step) begin
      cnt   <= cnt - CW'(1);
      rem_q <= rem_c;
      dvd_q <= dvd_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      busy <= (state_next != S_IDLE);
      done <= finish;
      if (finish) begin
        div_zero <= dz_q;
        if (dz_q) begin
          quotient  <= WIDTH'(DIV_ZERO_Q);
          remainder <= dvd_q;
        end else begin
          quotient  <= neg_q ? -dvd_q : dvd_q;
          remainder <= neg_r ? -rem_q : rem_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed vector bench for div_unit: results, latency, pulse shape, ignore/cancel/reset corners.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic        cancel = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_zero;
  logic [31:0] quotient, remainder;

  int errors = 0;
  int checks = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sign      (sign),
    .cancel    (cancel),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sg;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Launch one op; optionally re-assert start (60/7) at inj_at and cancel at cancel_at
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                        input int inj_at, input int cancel_at,
                        output int edges, output bit saw_done);
    @(negedge clk);
    dividend = a; divisor = b; sign = sg; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    edges = 0;
    saw_done = 1'b0;
    while (edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (done) begin
        saw_done = 1'b1;
        break;
      end
      if (edges == inj_at) begin
        dividend = 32'd60; divisor = 32'd7; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (edges == cancel_at) begin
        cancel = 1'b1;
      end else if (cancel) begin
        cancel = 1'b0;
        break;
      end
    end
  endtask

  vec_t vecs[11];
  int   edges;
  bit   saw_done;

  initial begin
    vecs[0]  = '{32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1'b0, 33};
    vecs[1]  = '{32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33};
    vecs[2]  = '{32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1,        1'b0, 33};
    vecs[3]  = '{32'd5,        32'd0,        1'b0, 32'hFFFFFFFF, 32'd5,        1'b1, 1};
    vecs[4]  = '{32'd5,        32'd0,        1'b1, 32'hFFFFFFFF, 32'd5,        1'b1, 1};
    vecs[5]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1'b0, 33};
    vecs[6]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000, 1'b0, 33};
    vecs[7]  = '{32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'd3,        32'hFFFFFFFF, 1'b0, 33};
    vecs[8]  = '{32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 32'd0,        1'b0, 33};
    vecs[9]  = '{32'd0,        32'd5,        1'b0, 32'd0,        32'd0,        1'b0, 33};
    vecs[10] = '{32'hFFFFFFFB, 32'd0,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1};

    #12;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_q", quotient, 32'd0);
    chk("reset_r", remainder, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sg, -1, -1, edges, saw_done);
      chk($sformatf("v%0d_latency", i), 32'(edges), 32'(vecs[i].lat));
      chk($sformatf("v%0d_q", i), quotient, vecs[i].q);
      chk($sformatf("v%0d_r", i), remainder, vecs[i].r);
      chk($sformatf("v%0d_dz", i), 32'(div_zero), 32'(vecs[i].dz));
      chk($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
    end

    // start+cancel together in IDLE is ignored
    @(negedge clk);
    dividend = 32'd9; divisor = 32'd3; start = 1'b1; cancel = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; cancel = 1'b0;
    chk("start_cancel_busy", 32'(busy), 32'd0);

    // start while busy is ignored
    run_op(32'd50, 32'd3, 1'b0, 5, -1, edges, saw_done);
    chk("restart_latency", 32'(edges), 32'd33);
    chk("restart_q", quotient, 32'd16);
    chk("restart_r", remainder, 32'd2);

    // cancel mid-op: idle on the next edge, no done, results held
    run_op(32'd100, 32'd7, 1'b0, -1, 10, edges, saw_done);
    chk("cancel_saw_done", 32'(saw_done), 32'd0);
    chk("cancel_busy", 32'(busy), 32'd0);
    chk("cancel_q", quotient, 32'd16);
    chk("cancel_r", remainder, 32'd2);
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    chk("cancel_no_late_done", 32'(saw_done), 32'd0);

    // asynchronous reset mid-CALC
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; sign = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_dz", 32'(div_zero), 32'd0);
    chk("midreset_q", quotient, 32'd0);
    chk("midreset_r", remainder, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd9, 32'd3, 1'b0, -1, -1, edges, saw_done);
    chk("postreset_latency", 32'(edges), 32'd33);
    chk("postreset_q", quotient, 32'd3);
    chk("postreset_r", remainder, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
